// File: rtl/rip_ex_alu.sv
// rip execute-stage ALU: one-hot decoded instruction in, one registered 32-bit result out.
// The result serves as branch flag, link value, address, write data or new CSR value.

package rip_const;

  typedef struct packed {
    logic LUI;
    logic AUIPC;
    logic JAL;
    logic JALR;
    logic BEQ;
    logic BNE;
    logic BLT;
    logic BGE;
    logic BLTU;
    logic BGEU;
    logic LB;
    logic LH;
    logic LW;
    logic LBU;
    logic LHU;
    logic SB;
    logic SH;
    logic SW;
    logic ADDI;
    logic SLTI;
    logic SLTIU;
    logic XORI;
    logic ORI;
    logic ANDI;
    logic SLLI;
    logic SRLI;
    logic SRAI;
    logic ADD;
    logic SUB;
    logic SLL;
    logic SLT;
    logic SLTU;
    logic XOR;
    logic SRL;
    logic SRA;
    logic OR;
    logic AND;
    logic CSRRW;
    logic CSRRS;
    logic CSRRC;
    logic CSRRWI;
    logic CSRRSI;
    logic CSRRCI;
    logic ECALL;
    logic MRET;
    logic UPDATE_PC;
    logic UPDATE_REG;
    logic UPDATE_CSR;
  } inst_t;

endpackage

module rip_ex_alu
  import rip_const::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  inst_t       inst,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] pc,
  input  logic [31:0] csr,
  input  logic [31:0] imm,
  input  logic [4:0]  zimm,
  output logic [31:0] rslt
);

  logic [31:0] rslt_d, rslt_q;
  logic [31:0] zimm_ext;
  logic [4:0]  shamt_r, shamt_i;

  // Control flags only steer the writeback stages, not the result value.
  logic unused_ctrl;
  assign unused_ctrl = ^{inst.UPDATE_PC, inst.UPDATE_REG, inst.UPDATE_CSR};

  assign zimm_ext = {27'b0, zimm};
  assign shamt_r  = rs2[4:0];
  assign shamt_i  = imm[4:0];

  always_comb begin
    rslt_d = '0;
    unique case (1'b1)
      inst.LUI:    rslt_d = imm;
      inst.AUIPC:  rslt_d = pc + imm;
      inst.JAL,
      inst.JALR:   rslt_d = pc + 32'd4;
      inst.BEQ:    rslt_d = {31'b0, rs1 == rs2};
      inst.BNE:    rslt_d = {31'b0, rs1 != rs2};
      inst.BLT:    rslt_d = {31'b0, $signed(rs1) <  $signed(rs2)};
      inst.BGE:    rslt_d = {31'b0, $signed(rs1) >= $signed(rs2)};
      inst.BLTU:   rslt_d = {31'b0, rs1 <  rs2};
      inst.BGEU:   rslt_d = {31'b0, rs1 >= rs2};
      inst.LB, inst.LH, inst.LW, inst.LBU, inst.LHU,
      inst.SB, inst.SH, inst.SW,
      inst.ADDI:   rslt_d = rs1 + imm;
      inst.SLTI:   rslt_d = {31'b0, $signed(rs1) < $signed(imm)};
      inst.SLTIU:  rslt_d = {31'b0, rs1 < imm};
      inst.XORI:   rslt_d = rs1 ^ imm;
      inst.ORI:    rslt_d = rs1 | imm;
      inst.ANDI:   rslt_d = rs1 & imm;
      inst.SLLI:   rslt_d = rs1 << shamt_i;
      inst.SRLI:   rslt_d = rs1 >> shamt_i;
      inst.SRAI:   rslt_d = $unsigned($signed(rs1) >>> shamt_i);
      inst.ADD:    rslt_d = rs1 + rs2;
      inst.SUB:    rslt_d = rs1 - rs2;
      inst.SLL:    rslt_d = rs1 << shamt_r;
      inst.SLT:    rslt_d = {31'b0, $signed(rs1) < $signed(rs2)};
      inst.SLTU:   rslt_d = {31'b0, rs1 < rs2};
      inst.XOR:    rslt_d = rs1 ^ rs2;
      inst.SRL:    rslt_d = rs1 >> shamt_r;
      inst.SRA:    rslt_d = $unsigned($signed(rs1) >>> shamt_r);
      inst.OR:     rslt_d = rs1 | rs2;
      inst.AND:    rslt_d = rs1 & rs2;
      inst.CSRRW:  rslt_d = rs1;
      inst.CSRRS:  rslt_d = csr | rs1;
      inst.CSRRC:  rslt_d = csr & ~rs1;
      inst.CSRRWI: rslt_d = zimm_ext;
      inst.CSRRSI: rslt_d = csr | zimm_ext;
      inst.CSRRCI: rslt_d = csr & ~zimm_ext;
      default:     rslt_d = '0;
    endcase
  end

  // Reset is high-true despite the port name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rslt_q <= '0;
    end else begin
      rslt_q <= rslt_d;
    end
  end

  assign rslt = rslt_q;

endmodule

// File: tb/tb_rip_ex_alu.sv
// Directed self-checking bench for rip_ex_alu with hand-computed expected results.

module tb_rip_ex_alu;
  import rip_const::*;

  logic        clk;
  logic        rst_n;
  inst_t       inst;
  logic [31:0] rs1, rs2, pc, csr, imm;
  logic [4:0]  zimm;
  logic [31:0] rslt;

  int n_pass;
  int n_total;

  rip_ex_alu dut (
    .clk  (clk),
    .rst_n(rst_n),
    .inst (inst),
    .rs1  (rs1),
    .rs2  (rs2),
    .pc   (pc),
    .csr  (csr),
    .imm  (imm),
    .zimm (zimm),
    .rslt (rslt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive operands, clock one edge, leave #1 after it for sampling.
  task automatic apply(input inst_t i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] c, input logic [31:0] im,
                       input logic [4:0] z);
    inst = i;
    rs1  = a;
    rs2  = b;
    pc   = p;
    csr  = c;
    imm  = im;
    zimm = z;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    inst_t i;
    i = '0;
    i.ADD = 1'b1;
    rst_n = 1'b1;
    apply(i, 32'd5, 32'd7, 32'h0, 32'h0, 32'h0, 5'h0);
    n_total++;
    if (rslt !== 32'h0) $display("FAIL reset_hold: got %h want %h", rslt, 32'h0);
    else n_pass++;
    rst_n = 1'b0;
    apply(i, 32'd5, 32'd7, 32'h0, 32'h0, 32'h0, 5'h0);
    n_total++;
    if (rslt !== 32'd12) $display("FAIL reset_release_add: got %h want %h", rslt, 32'd12);
    else n_pass++;
  endtask

  task automatic test_arith();
    inst_t i;
    i = '0; i.ADD = 1'b1;
    apply(i, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0, 5'h0);
    n_total++;
    if (rslt !== 32'h0) $display("FAIL add_wrap: got %h want %h", rslt, 32'h0);
    else n_pass++;
    i = '0; i.SUB = 1'b1;
    apply(i, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 5'h0);
    n_total++;
    if (rslt !== 32'hFFFF_FFFF) $display("FAIL sub_wrap: got %h want %h", rslt, 32'hFFFF_FFFF);
    else n_pass++;
    i = '0; i.SRA = 1'b1;
    apply(i, 32'h8000_0000, 32'h24, 32'h0, 32'h0, 32'h0, 5'h0);
    n_total++;
    if (rslt !== 32'hF800_0000) $display("FAIL sra: got %h want %h", rslt, 32'hF800_0000);
    else n_pass++;
    i = '0; i.SRL = 1'b1;
    apply(i, 32'h8000_0000, 32'h24, 32'h0, 32'h0, 32'h0, 5'h0);
    n_total++;
    if (rslt !== 32'h0800_0000) $display("FAIL srl: got %h want %h", rslt, 32'h0800_0000);
    else n_pass++;
    i = '0; i.SLLI = 1'b1;
    apply(i, 32'h1, 32'h0, 32'h0, 32'h0, 32'h21, 5'h0);
    n_total++;
    if (rslt !== 32'h2) $display("FAIL slli: got %h want %h", rslt, 32'h2);
    else n_pass++;
    i = '0; i.XORI = 1'b1;
    apply(i, 32'hFF, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'h0);
    n_total++;
    if (rslt !== 32'hFFFF_FF00) $display("FAIL xori: got %h want %h", rslt, 32'hFFFF_FF00);
    else n_pass++;
  endtask

  task automatic test_compare();
    inst_t i;
    i = '0; i.SLT = 1'b1;
    apply(i, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0, 5'h0);
    n_total++;
    if (rslt !== 32'h1) $display("FAIL slt: got %h want %h", rslt, 32'h1);
    else n_pass++;
    i = '0; i.SLTU = 1'b1;
    apply(i, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0, 5'h0);
    n_total++;
    if (rslt !== 32'h0) $display("FAIL sltu: got %h want %h", rslt, 32'h0);
    else n_pass++;
    i = '0; i.BGEU = 1'b1;
    apply(i, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0, 5'h0);
    n_total++;
    if (rslt !== 32'h1) $display("FAIL bgeu: got %h want %h", rslt, 32'h1);
    else n_pass++;
    i = '0; i.BLT = 1'b1;
    apply(i, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0, 5'h0);
    n_total++;
    if (rslt !== 32'h1) $display("FAIL blt: got %h want %h", rslt, 32'h1);
    else n_pass++;
    i = '0; i.BEQ = 1'b1;
    apply(i, 32'd3, 32'd4, 32'h0, 32'h0, 32'h0, 5'h0);
    n_total++;
    if (rslt !== 32'h0) $display("FAIL beq: got %h want %h", rslt, 32'h0);
    else n_pass++;
    i = '0; i.SLTIU = 1'b1;
    apply(i, 32'd5, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'h0);
    n_total++;
    if (rslt !== 32'h1) $display("FAIL sltiu: got %h want %h", rslt, 32'h1);
    else n_pass++;
  endtask

  task automatic test_jump_mem_upper();
    inst_t i;
    i = '0; i.JAL = 1'b1;
    apply(i, 32'h0, 32'h0, 32'h8000, 32'h0, 32'h0, 5'h0);
    n_total++;
    if (rslt !== 32'h8004) $display("FAIL jal: got %h want %h", rslt, 32'h8004);
    else n_pass++;
    i = '0; i.LW = 1'b1;
    apply(i, 32'h100, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'h0);
    n_total++;
    if (rslt !== 32'hFC) $display("FAIL lw_addr: got %h want %h", rslt, 32'hFC);
    else n_pass++;
    i = '0; i.AUIPC = 1'b1;
    apply(i, 32'h0, 32'h0, 32'h8000, 32'h0, 32'h1000, 5'h0);
    n_total++;
    if (rslt !== 32'h9000) $display("FAIL auipc: got %h want %h", rslt, 32'h9000);
    else n_pass++;
    i = '0; i.LUI = 1'b1;
    apply(i, 32'h0, 32'h0, 32'h0, 32'h0, 32'hABCD_E000, 5'h0);
    n_total++;
    if (rslt !== 32'hABCD_E000) $display("FAIL lui: got %h want %h", rslt, 32'hABCD_E000);
    else n_pass++;
    i = '0; i.ECALL = 1'b1;
    apply(i, 32'h1234, 32'h55, 32'h8000, 32'hFF, 32'h10, 5'h3);
    n_total++;
    if (rslt !== 32'h0) $display("FAIL ecall: got %h want %h", rslt, 32'h0);
    else n_pass++;
  endtask

  task automatic test_csr();
    inst_t i;
    i = '0; i.CSRRS = 1'b1;
    apply(i, 32'h0F, 32'h0, 32'h0, 32'hF0, 32'h0, 5'h0);
    n_total++;
    if (rslt !== 32'hFF) $display("FAIL csrrs: got %h want %h", rslt, 32'hFF);
    else n_pass++;
    i = '0; i.CSRRC = 1'b1;
    apply(i, 32'h0F, 32'h0, 32'h0, 32'hFF, 32'h0, 5'h0);
    n_total++;
    if (rslt !== 32'hF0) $display("FAIL csrrc: got %h want %h", rslt, 32'hF0);
    else n_pass++;
    i = '0; i.CSRRWI = 1'b1;
    apply(i, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'h1F);
    n_total++;
    if (rslt !== 32'h1F) $display("FAIL csrrwi: got %h want %h", rslt, 32'h1F);
    else n_pass++;
    i = '0; i.CSRRCI = 1'b1;
    apply(i, 32'h0, 32'h0, 32'h0, 32'hFF, 32'h0, 5'h0F);
    n_total++;
    if (rslt !== 32'hF0) $display("FAIL csrrci: got %h want %h", rslt, 32'hF0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    inst_t i;
    logic [31:0] exp;
    for (int k = 0; k < 4; k++) begin
      i = '0;
      if (k % 2 == 0) i.ADD = 1'b1;
      exp = (k % 2 == 0) ? 32'd2 : 32'd0;
      apply(i, 32'd1, 32'd1, 32'h0, 32'h0, 32'h0, 5'h0);
      n_total++;
      if (rslt !== exp) $display("FAIL b2b_%0d: got %h want %h", k, rslt, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    inst_t i;
    i = '0; i.ADD = 1'b1;
    apply(i, 32'd10, 32'd20, 32'h0, 32'h0, 32'h0, 5'h0);
    n_total++;
    if (rslt !== 32'd30) $display("FAIL mid_pre: got %h want %h", rslt, 32'd30);
    else n_pass++;
    rst_n = 1'b1;
    apply(i, 32'd40, 32'd2, 32'h0, 32'h0, 32'h0, 5'h0);
    n_total++;
    if (rslt !== 32'h0) $display("FAIL mid_reset: got %h want %h", rslt, 32'h0);
    else n_pass++;
    rst_n = 1'b0;
    apply(i, 32'd40, 32'd3, 32'h0, 32'h0, 32'h0, 5'h0);
    n_total++;
    if (rslt !== 32'd43) $display("FAIL mid_release: got %h want %h", rslt, 32'd43);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b1;
    inst    = '0;
    rs1     = '0;
    rs2     = '0;
    pc      = '0;
    csr     = '0;
    imm     = '0;
    zimm    = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_arith();
    test_compare();
    test_jump_mem_upper();
    test_csr();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rip_ex_alu.md
# rip_ex_alu

Registered RV32I/Zicsr execute-stage ALU of the rip pipeline. It consumes the one-hot decoded instruction from the DE stage together with forwarded operands (rs1, rs2, pc, csr, imm, zimm). On every clock edge it registers one 32-bit result. That result is consumed in the following cycle as branch-taken flag, link value, memory address, register write data, or new CSR value.

## Interface
- No parameters. Instruction type `inst_t` comes from package `rip_const`: packed one-hot flag struct.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous, active-high (rst_n=1 at a rising edge clears state).
- `inst`  in  `inst_t`  decoded instruction.
  - Flags: LUI AUIPC JAL JALR BEQ BNE BLT BGE BLTU BGEU LB LH LW LBU LHU SB SH SW ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI ADD SUB SLL SLT SLTU XOR SRL SRA OR AND CSRRW CSRRS CSRRC CSRRWI CSRRSI CSRRCI ECALL MRET.
  - Control flags: UPDATE_PC UPDATE_REG UPDATE_CSR.
  - All-zero means bubble.
- `rs1`, `rs2`  in  32  forwarded register operands.
- `pc`  in  32  address of the instruction.
- `csr`  in  32  forwarded current value of the addressed CSR.
- `imm`  in  32  immediate, already sign-extended and formatted by the decoder (I/S/B/U/J).
- `zimm`  in  5  CSR immediate, zero-extended internally.
- `rslt`  out  32  registered result.

## Operation
- Each rising edge, `rslt` loads f(inputs) sampled at that edge. There is no enable.
- Selection is by the single asserted flag. If no flag or an unlisted flag is set, the result is 0.
- Priority is irrelevant for legal input: decoder guarantees at most one instruction flag set.
- LUI: result = imm. AUIPC: result = pc+imm.
- JAL, JALR: result = pc+4 (link value; target computed outside).
- Branches: result = {31'b0, taken}.
  - BEQ: rs1==rs2. BNE: rs1!=rs2.
  - BLT/BGE: signed rs1<rs2 / rs1>=rs2.
  - BLTU/BGEU: unsigned rs1<rs2 / rs1>=rs2.
- Loads and stores: result = rs1+imm (byte address).
- ADD/ADDI: rs1+rs2 / rs1+imm. SUB: rs1-rs2.
- Compare ops produce a 0/1 result.
  - SLT/SLTI: signed compare.
  - SLTU/SLTIU: unsigned compare; imm is sign-extended first.
- XOR, OR, AND (and their -I forms): bitwise operations.
- Shifts:
  - Shift amount is rs2[4:0] for register forms and imm[4:0] for immediate forms.
  - SRA/SRAI replicate rs1[31].
- Arithmetic is modulo 2^32 with no overflow flag.
- CSR ops: result = new CSR value. The old value is passed through separately by the pipeline.
  - CSRRW = rs1; CSRRS = csr|rs1; CSRRC = csr&~rs1.
  - CSRRWI = {27'b0,zimm}; CSRRSI = csr|zimm; CSRRCI = csr&~zimm.
- ECALL, MRET: result = 0 (redirect handled by core).

## Timing
- Latency 1 cycle: inputs valid before edge N give `rslt` valid after edge N, stable until edge N+1.
- Reset: `rst_n`=1 at an edge gives `rslt`=0 after that edge.
  - Reset dominates inputs.
  - Reset asserted mid-stream discards the in-flight result.
  - First result after release reflects inputs at the first non-reset edge.
- The path to `rslt` is purely combinational: no multi-cycle ops, no stall input, no handshake. Pipeline bubbles are all-zero `inst`, which gives `rslt`=0.
- Back-to-back dependent instructions are supported; forwarding is external.

## Test plan
- Reset: drive ADD with rs1=5, rs2=7 while rst_n=1 → rslt=0. Release reset; next edge → rslt=12.
- Arithmetic wrap/shift:
  - ADD 0xFFFFFFFF+1 → 0.
  - SUB 0−1 → 0xFFFFFFFF.
  - SRA 0x80000000 by rs2=0x24 (amount 4) → 0xF8000000.
  - SRL same operands → 0x08000000.
- Compares:
  - SLT rs1=0xFFFFFFFF, rs2=1 → 1.
  - SLTU same operands → 0.
  - BGEU same operands → rslt[0]=1.
  - BEQ 3,4 → 0.
- Jump/memory/upper:
  - JAL pc=0x8000 → 0x8004.
  - LW rs1=0x100, imm=0xFFFFFFFC → 0xFC.
  - AUIPC pc=0x8000, imm=0x1000 → 0x9000.
  - LUI imm=0xABCDE000 → 0xABCDE000.
- CSR:
  - CSRRS csr=0xF0, rs1=0x0F → 0xFF.
  - CSRRC csr=0xFF, rs1=0x0F → 0xF0.
  - CSRRWI zimm=0x1F → 0x1F.
- Latency/bubble: alternate ADD (1+1) and all-zero inst on consecutive edges → rslt sequence 2,0,2,0, each value one cycle after its input.
